// File: rtl/uart_pkg.sv
// Shared register map, status bit positions and FSM state encoding for the
// APB UART peripheral.
package uart_pkg;

  // Register byte offsets within the peripheral slot.
  localparam logic [3:0] USR_OFS = 4'h0;
  localparam logic [3:0] TDR_OFS = 4'h4;
  localparam logic [3:0] RDR_OFS = 4'h8;

  // USR bit positions.
  localparam int USR_RXV = 0;  // rx_valid
  localparam int USR_TXF = 1;  // tx_full
  localparam int USR_TXE = 2;  // tx_empty
  localparam int USR_OVR = 3;  // overrun
  localparam int USR_FE  = 4;  // framing error

  // Common state encoding for the TX and RX framers.
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO. A push into a full FIFO is accepted only when a
// pop happens on the same edge; otherwise it is dropped.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // Storage array write port.
  // NOTE: the data array is deliberately not reset; pointers/count define validity.
  always_ff @(posedge PCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_periph.sv
// APB responder UART: 8N1, LSB first, TX FIFO and single-byte RX holding
// register, fixed one-wait-state APB response.
module apb_uart_periph
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx,
  input  logic        rx
);

  localparam int TICK_DIV = CLK_HZ / (BAUD * 16);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  logic          pready_q;
  logic [31:0]   prdata_q, rd_data, usr_val;
  logic          apb_access, wr_tdr, rd_rdr, rd_usr;

  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty, tx_pop;
  uart_state_e   tx_state_q;
  logic [3:0]    tx_tcnt_q;
  logic [2:0]    tx_idx_q;
  logic [7:0]    tx_shift_q;
  logic          tx_q;

  logic          rx_meta_q, rx_sync_q;
  uart_state_e   rx_state_q;
  logic [3:0]    rx_tcnt_q;
  logic [2:0]    rx_idx_q;
  logic [7:0]    rx_shift_q, rx_byte_q;
  logic          rx_valid_q, ovr_q, fe_q;

  logic          unused_pwdata;
  assign unused_pwdata = ^PWDATA[31:8];

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Free-running 16x oversampling tick generator.
  always_ff @(posedge PCLK) begin
    if (PRESET || tick) tick_cnt_q <= '0;
    else                tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // Side effects fire only on the edge that raises PREADY.
  assign apb_access = PSEL & PENABLE & ~pready_q;
  assign wr_tdr     = apb_access &  PWRITE & (PADDR == TDR_OFS);
  assign rd_rdr     = apb_access & ~PWRITE & (PADDR == RDR_OFS);
  assign rd_usr     = apb_access & ~PWRITE & (PADDR == USR_OFS);

  // Status word and read-data mux.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    usr_val          = '0;
    usr_val[USR_RXV] = rx_valid_q;
    usr_val[USR_TXF] = fifo_full;
    usr_val[USR_TXE] = fifo_empty & (tx_state_q == IDLE);
    usr_val[USR_OVR] = ovr_q;
    usr_val[USR_FE]  = fe_q;
    rd_data          = '0;
    if (!PWRITE) begin
      case (PADDR)
        USR_OFS: rd_data = usr_val;
        RDR_OFS: rd_data = {24'b0, rx_byte_q};
        default: rd_data = '0;
      endcase
    end
  end

  // Registered APB response: one-cycle PREADY pulse with its read data.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      pready_q <= apb_access;
      prdata_q <= apb_access ? rd_data : '0;
    end
  end

  assign PREADY = pready_q;
  assign PRDATA = prdata_q;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .push  (wr_tdr),
    .pop   (tx_pop),
    .wdata (PWDATA[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pop when idle, or at the end of a stop bit for back-to-back frames.
  assign tx_pop = tick & ~fifo_empty &
                  ((tx_state_q == IDLE) | ((tx_state_q == STOP) & (tx_tcnt_q == 4'd15)));

  // TX framer: each state lasts 16 ticks, tx is a registered output.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_state_q <= IDLE;
      tx_tcnt_q  <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else if (tick) begin
      case (tx_state_q)
        IDLE: if (tx_pop) begin
          tx_shift_q <= fifo_rdata;
          tx_tcnt_q  <= '0;
          tx_q       <= 1'b0;
          tx_state_q <= START;
        end
        START: if (tx_tcnt_q == 4'd15) begin
          tx_tcnt_q  <= '0;
          tx_idx_q   <= '0;
          tx_q       <= tx_shift_q[0];
          tx_state_q <= DATA;
        end else tx_tcnt_q <= tx_tcnt_q + 4'd1;
        DATA: if (tx_tcnt_q == 4'd15) begin
          tx_tcnt_q <= '0;
          if (tx_idx_q == 3'd7) begin
            tx_q       <= 1'b1;
            tx_state_q <= STOP;
          end else begin
            tx_idx_q   <= tx_idx_q + 3'd1;
            tx_shift_q <= tx_shift_q >> 1;
            tx_q       <= tx_shift_q[1];
          end
        end else tx_tcnt_q <= tx_tcnt_q + 4'd1;
        STOP: if (tx_tcnt_q == 4'd15) begin
          tx_tcnt_q <= '0;
          if (tx_pop) begin
            tx_shift_q <= fifo_rdata;
            tx_q       <= 1'b0;
            tx_state_q <= START;
          end else tx_state_q <= IDLE;
        end else tx_tcnt_q <= tx_tcnt_q + 4'd1;
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  assign tx = tx_q;

  // Two-flop synchronizer for the asynchronous rx line (idles high).
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX framer and status flags; frame events are written last so a
  // same-cycle set beats a host clear.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_state_q <= IDLE;
      rx_tcnt_q  <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      if (rd_rdr) rx_valid_q <= 1'b0;
      if (rd_usr) begin
        ovr_q <= 1'b0;
        fe_q  <= 1'b0;
      end
      if (tick) begin
        case (rx_state_q)
          IDLE: if (!rx_sync_q) begin
            rx_tcnt_q  <= '0;
            rx_state_q <= START;
          end
          START: if (rx_tcnt_q == 4'd7) begin
            rx_tcnt_q  <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rx_sync_q ? IDLE : DATA;
          end else rx_tcnt_q <= rx_tcnt_q + 4'd1;
          DATA: if (rx_tcnt_q == 4'd15) begin
            rx_tcnt_q  <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_idx_q == 3'd7) rx_state_q <= STOP;
            else                  rx_idx_q   <= rx_idx_q + 3'd1;
          end else rx_tcnt_q <= rx_tcnt_q + 4'd1;
          STOP: if (rx_tcnt_q == 4'd15) begin
            rx_tcnt_q  <= '0;
            rx_state_q <= IDLE;
            if (!rx_sync_q) fe_q <= 1'b1;
            else if (!rx_valid_q || rd_rdr) begin
              rx_byte_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end else ovr_q <= 1'b1;
          end else rx_tcnt_q <= rx_tcnt_q + 4'd1;
          default: rx_state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_periph.sv
// Scoreboard bench for apb_uart_periph: APB reads and TX frames are queued as
// expectations by the stimulus and checked by independent monitors.
module tb_apb_uart_periph;
  import uart_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [3:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        tx;
  logic        rx;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;

  assign rx = loop_en ? tx : rx_drv;

  apb_uart_periph #(.CLK_HZ(1_600_000), .BAUD(100_000), .FIFO_DEPTH(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .tx(tx), .rx(rx)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // APB expectations: one entry per transfer issued.
  logic        apb_rd_q [$];
  logic [31:0] apb_exp_q [$];
  string       apb_nm_q [$];
  // TX expectations: byte and whether it must follow the previous frame with no gap.
  logic [7:0]  tx_exp_q [$];
  logic        tx_b2b_q [$];
  logic        tx_mon_en = 1'b0;
  logic        tx_mon_busy = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // APB monitor: compares PRDATA of every completed read and the pulse width.
  initial begin
    logic prev_ready;
    logic is_rd;
    logic [31:0] e;
    string nm;
    prev_ready = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!PRESET && PREADY) begin
        if (apb_rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL apb_unexpected actual=PREADY required=no transfer");
        end else begin
          is_rd = apb_rd_q.pop_front();
          e     = apb_exp_q.pop_front();
          nm    = apb_nm_q.pop_front();
          if (is_rd) check(nm, PRDATA, e);
          check({nm, "_pready_len"}, 32'(prev_ready), 32'd0);
        end
      end
      prev_ready = PREADY;
    end
  end

  // TX monitor: checks every cycle of each 160-cycle frame and frame spacing.
  initial begin
    logic [7:0] exp_b, got;
    logic       b2b;
    logic [2:0] bi;
    logic       e;
    int         bad, s, prev_s;
    prev_s = -1000;
    forever begin
      @(negedge PCLK);
      if (tx_mon_en && !PRESET && tx === 1'b0) begin
        tx_mon_busy = 1'b1;
        s = cyc;
        if (tx_exp_q.size() == 0) begin
          exp_b = 8'h00;
          b2b   = 1'b0;
          checks++;
          errors++;
          $display("FAIL tx_unexpected_frame actual=start bit required=idle");
        end else begin
          exp_b = tx_exp_q.pop_front();
          b2b   = tx_b2b_q.pop_front();
        end
        bad = 0;
        got = '0;
        for (int t = 0; t < 160; t++) begin
          bi = 3'((t - 16) / 16);
          if (t < 16)       e = 1'b0;
          else if (t < 144) e = exp_b[bi];
          else              e = 1'b1;
          if (tx !== e) bad++;
          if (t >= 16 && t < 144 && (t % 16) == 8) got[bi] = tx;
          if (t < 159) @(negedge PCLK);
        end
        check("tx_frame_byte", {24'b0, got}, {24'b0, exp_b});
        check("tx_frame_cycles_wrong", 32'(bad), 32'd0);
        if (b2b) check("tx_b2b_gap", 32'(s - prev_s), 32'd160);
        prev_s = s;
        tx_mon_busy = 1'b0;
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input string nm);
    int n;
    apb_rd_q.push_back(!wr);
    apb_exp_q.push_back(exp);
    apb_nm_q.push_back(nm);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!PREADY && n < 8);
    if (!PREADY) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no PREADY required=PREADY", nm);
    end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr_tdr(input logic [7:0] b, input logic exp_frame, input logic b2b);
    if (exp_frame) begin
      tx_exp_q.push_back(b);
      tx_b2b_q.push_back(b2b);
    end
    apb_xfer(1'b1, TDR_OFS, {24'hABCDEF, b}, 32'd0, "wr_tdr");
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    apb_xfer(1'b0, a, 32'd0, exp, nm);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (16) @(negedge PCLK);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_tx_done(input int budget);
    int n;
    n = 0;
    while ((tx_exp_q.size() != 0 || tx_mon_busy) && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    check("tx_drain_pending", 32'(tx_exp_q.size() != 0 || tx_mon_busy), 32'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge PCLK);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_pready", 32'(PREADY), 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    PRESET = 1'b0;

    // 1. Reset in the middle of a frame, with a second byte still queued.
    wr_tdr(8'h55, 1'b0, 1'b0);
    wr_tdr(8'h66, 1'b0, 1'b0);
    repeat (37) @(negedge PCLK);
    check("t1_tx_mid_frame", 32'(tx), 32'd0);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("t1_tx_after_rst", 32'(tx), 32'd1);
    check("t1_pready_rst", 32'(PREADY), 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    rd(USR_OFS, 32'h04, "t1_usr");
    repeat (200) @(negedge PCLK);
    check("t1_tx_idle_fifo_lost", 32'(tx), 32'd1);
    tx_mon_en = 1'b1;

    // 2. Single byte.
    wr_tdr(8'hA5, 1'b1, 1'b0);
    wait_tx_done(400);
    rd(USR_OFS, 32'h04, "t2_usr");

    // 3. Burst of five fills the FIFO; a sixth is dropped while full.
    wr_tdr(8'h11, 1'b1, 1'b0);
    wr_tdr(8'h22, 1'b1, 1'b1);
    wr_tdr(8'h33, 1'b1, 1'b1);
    wr_tdr(8'h44, 1'b1, 1'b1);
    wr_tdr(8'h55, 1'b1, 1'b1);
    rd(USR_OFS, 32'h02, "t3_usr_full");
    wr_tdr(8'h66, 1'b0, 1'b0);
    wait_tx_done(2000);
    rd(USR_OFS, 32'h04, "t3_usr_drained");

    // 4. One received byte.
    send_rx(8'h3C, 1'b1);
    rd(USR_OFS, 32'h05, "t4_usr_valid");
    rd(RDR_OFS, 32'h3C, "t4_rdr");
    rd(USR_OFS, 32'h04, "t4_usr_after");

    // 5. Overrun: second byte lost, first kept.
    send_rx(8'h01, 1'b1);
    send_rx(8'h02, 1'b1);
    rd(USR_OFS, 32'h0D, "t5_usr_ovr");
    rd(RDR_OFS, 32'h01, "t5_rdr");
    rd(USR_OFS, 32'h04, "t5_usr_after");

    // 6. False start, framing error, then external loopback.
    rx_drv = 1'b0;
    repeat (4) @(negedge PCLK);
    rx_drv = 1'b1;
    repeat (40) @(negedge PCLK);
    rd(USR_OFS, 32'h04, "t6_usr_glitch");
    send_rx(8'h99, 1'b0);
    repeat (40) @(negedge PCLK);
    rd(USR_OFS, 32'h14, "t6_usr_fe");
    rd(USR_OFS, 32'h04, "t6_usr_fe_cleared");
    loop_en = 1'b1;
    wr_tdr(8'h7E, 1'b1, 1'b0);
    wait_tx_done(400);
    repeat (20) @(negedge PCLK);
    rd(RDR_OFS, 32'h7E, "t6_rdr_loopback");
    rd(USR_OFS, 32'h04, "t6_usr_final");

    repeat (4) @(negedge PCLK);
    check("apb_queue_pending", 32'(apb_rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
